// File: rtl/extended_wire_pkg.sv
// Shared types and sizes for the 64-bit extended wire path (sender and receiver).
// An entry is {address, data}; a frame is one address word plus four data words.
package extended_wire_pkg;

  localparam int WORD_W      = 16;
  localparam int DATA_WORDS  = 4;
  localparam int FRAME_WORDS = 5;
  localparam int ADDR_W      = 16;
  localparam int DATA_W      = WORD_W * DATA_WORDS;
  localparam int ENTRY_W     = ADDR_W + DATA_W;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ADDR = 3'd1,
    D0   = 3'd2,
    D1   = 3'd3,
    D2   = 3'd4,
    D3   = 3'd5
  } state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } entry_t;

  // Data words go out least significant first.
  function automatic logic [WORD_W-1:0] data_word(input logic [DATA_W-1:0] d,
                                                  input logic [1:0]        idx);
    return d[idx*WORD_W +: WORD_W];
  endfunction

endpackage

// File: rtl/ext_wire_fifo.sv
// Synchronous FIFO with same-edge push/pop; a push into a full FIFO is accepted
// only when a pop frees the slot on the same edge.
module ext_wire_fifo #(
  parameter int WIDTH = 80,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic [WIDTH-1:0]         i_din,
  output logic [WIDTH-1:0]         o_dout,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full    = (r_count == CW'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_dout    = r_mem[r_rd_ptr];
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage carries data only, so it is left out of reset.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_din;
  end

endmodule

// File: rtl/extended_wire_sender.sv
// Queues {address, 64-bit data} entries and serializes each as a 5-word frame.
// Optional EXTENDED_WIRE_SENDER_DEDUP_EN discards loads equal to the last accepted entry.
module extended_wire_sender
  import extended_wire_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [DATA_W-1:0]      data_in,
  input  logic [ADDR_W-1:0]      address_in,
  input  logic                   load,
  output logic                   full,
  output logic [$clog2(DEPTH):0] pending,
  output logic [WORD_W-1:0]      word_out,
  output logic                   word_valid,
  input  logic                   word_ready,
  output logic                   frame_start,
  output logic                   overflow,
  input  logic                   clear_overflow
);

  localparam int CW = $clog2(DEPTH) + 1;

  state_t           r_state;
  state_t           w_state_nxt;
  entry_t           r_frame;
  logic             r_overflow;
  logic [ENTRY_W-1:0] w_fifo_dout;
  logic             w_fifo_full;
  logic             w_fifo_empty;
  logic [CW-1:0]    w_fifo_count;
  logic             w_pop;
  logic             w_dup;
  logic             w_load_ok;
  logic             w_drop;
  logic             w_accept;

`ifdef EXTENDED_WIRE_SENDER_DEDUP_EN
  logic [ENTRY_W-1:0] r_last;

  assign w_dup = ({address_in, data_in} == r_last);

  always_ff @(posedge clk) begin
    if (!rst_n)        r_last <= '0;
    else if (w_accept) r_last <= {address_in, data_in};
  end
`else
  assign w_dup = 1'b0;
`endif

  // Pop into the frame register from IDLE, or straight after the last data
  // word so back-to-back frames leave no bubble.
  assign w_pop     = !w_fifo_empty &&
                     ((r_state == IDLE) || ((r_state == D3) && word_ready));
  assign w_load_ok = load && !w_dup;
  assign w_drop    = w_load_ok && w_fifo_full && !w_pop;
  assign w_accept  = w_load_ok && !w_drop;

  ext_wire_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_load_ok),
    .i_pop   (w_pop),
    .i_din   ({address_in, data_in}),
    .o_dout  (w_fifo_dout),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty),
    .o_count (w_fifo_count)
  );

  assign full     = w_fifo_full;
  assign pending  = w_fifo_count;
  assign overflow = r_overflow;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_overflow <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_drop)              r_overflow <= 1'b1;
      else if (clear_overflow) r_overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (w_pop) r_frame <= entry_t'(w_fifo_dout);
  end

  always_comb begin
    w_state_nxt = r_state;
    word_out    = '0;
    word_valid  = 1'b0;
    frame_start = 1'b0;
    case (r_state)
      IDLE: begin
        if (!w_fifo_empty) w_state_nxt = ADDR;
      end
      ADDR: begin
        word_valid  = 1'b1;
        frame_start = 1'b1;
        word_out    = r_frame.addr;
        if (word_ready) w_state_nxt = D0;
      end
      D0: begin
        word_valid = 1'b1;
        word_out   = data_word(r_frame.data, 2'd0);
        if (word_ready) w_state_nxt = D1;
      end
      D1: begin
        word_valid = 1'b1;
        word_out   = data_word(r_frame.data, 2'd1);
        if (word_ready) w_state_nxt = D2;
      end
      D2: begin
        word_valid = 1'b1;
        word_out   = data_word(r_frame.data, 2'd2);
        if (word_ready) w_state_nxt = D3;
      end
      D3: begin
        word_valid = 1'b1;
        word_out   = data_word(r_frame.data, 2'd3);
        if (word_ready) w_state_nxt = w_fifo_empty ? IDLE : ADDR;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_extended_wire_sender.sv
// Bench for extended_wire_sender: queue-level reference model checked every cycle,
// plus directed scenarios with hand-computed frame contents.
module tb_extended_wire_sender;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [63:0] data_in = '0;
  logic [15:0] address_in = '0;
  logic        load = 1'b0;
  logic        word_ready = 1'b0;
  logic        clear_overflow = 1'b0;
  logic        full;
  logic [2:0]  pending;
  logic [15:0] word_out;
  logic        word_valid;
  logic        frame_start;
  logic        overflow;

  extended_wire_sender #(.DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .data_in        (data_in),
    .address_in     (address_in),
    .load           (load),
    .full           (full),
    .pending        (pending),
    .word_out       (word_out),
    .word_valid     (word_valid),
    .word_ready     (word_ready),
    .frame_start    (frame_start),
    .overflow       (overflow),
    .clear_overflow (clear_overflow)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  task automatic chk(input string nm, input logic [79:0] act, input logic [79:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Reference model: queue of waiting entries plus the frame on the wire.
  logic [79:0] mq[$];
  logic [79:0] cur = '0;
  bit          inflight = 0;
  int          widx = 0;
  bit          m_ovf = 0;
  logic [79:0] m_last = '0;
  bit          started = 0;
  logic [15:0] sink[$];
  bit          sink_fs[$];

  function automatic logic [15:0] exp_word();
    if (!inflight) return 16'h0;
    if (widx == 0) return cur[79:64];
    return cur[(widx-1)*16 +: 16];
  endfunction

  always @(posedge clk) begin : model
    bit xfer, fin, pop, dup, set_ovf;
    int sz;
    started = 1;
    if (rst_n && word_valid && word_ready) begin
      sink.push_back(word_out);
      sink_fs.push_back(frame_start);
    end
    if (!rst_n) begin
      mq.delete();
      inflight = 0;
      widx     = 0;
      m_ovf    = 0;
      m_last   = '0;
    end else begin
      sz      = mq.size();
      xfer    = inflight && word_ready;
      fin     = xfer && (widx == 4);
      pop     = (!inflight || fin) && (sz > 0);
      set_ovf = 0;
      if (xfer && widx < 4) widx++;
      if (fin) inflight = 0;
      if (pop) begin
        cur      = mq.pop_front();
        inflight = 1;
        widx     = 0;
      end
`ifdef EXTENDED_WIRE_SENDER_DEDUP_EN
      dup = ({address_in, data_in} == m_last);
`else
      dup = 0;
`endif
      if (load && !dup) begin
        if (sz < DEPTH || pop) begin
          mq.push_back({address_in, data_in});
          m_last = {address_in, data_in};
        end else begin
          set_ovf = 1;
        end
      end
      if (set_ovf) m_ovf = 1;
      else if (clear_overflow) m_ovf = 0;
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("cyc_valid",    word_valid,  inflight);
      chk("cyc_word",     word_out,    exp_word());
      chk("cyc_fstart",   frame_start, inflight && (widx == 0));
      chk("cyc_pending",  pending,     mq.size());
      chk("cyc_full",     full,        mq.size() == DEPTH);
      chk("cyc_overflow", overflow,    m_ovf);
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic do_load(input logic [15:0] a, input logic [63:0] d);
    address_in = a;
    data_in    = d;
    load       = 1'b1;
    tick();
    load       = 1'b0;
  endtask

  task automatic frame_chk(input string nm, input int f, input logic [15:0] a, input logic [63:0] d);
    logic [15:0] exp [5];
    exp[0] = a;
    exp[1] = d[15:0];
    exp[2] = d[31:16];
    exp[3] = d[47:32];
    exp[4] = d[63:48];
    if (sink.size() >= f*5 + 5) begin
      for (int j = 0; j < 5; j++) begin
        chk({nm, "_word"}, sink[f*5+j], exp[j]);
        chk({nm, "_fs"},   sink_fs[f*5+j], j == 0);
      end
    end else begin
      chk({nm, "_missing"}, sink.size(), f*5 + 5);
    end
  endtask

  function automatic int count_frames();
    int n = 0;
    foreach (sink_fs[k]) if (sink_fs[k]) n++;
    return n;
  endfunction

  task automatic pulse_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int nval;
    int exp_frames;
    logic [63:0] sf_data;
    sf_data = 64'h1111_2222_3333_4444;

    // Reset values
    run(3);
    chk("rst_valid",    word_valid,  1'b0);
    chk("rst_word",     word_out,    16'h0);
    chk("rst_fstart",   frame_start, 1'b0);
    chk("rst_full",     full,        1'b0);
    chk("rst_pending",  pending,     3'd0);
    chk("rst_overflow", overflow,    1'b0);
    rst_n = 1'b1;
    tick();

    // Single frame, latency and length
    word_ready = 1'b1;
    sink.delete(); sink_fs.delete();
    do_load(16'h0012, sf_data);
    chk("sf_lat_edge_n", word_valid, 1'b0);
    tick();
    chk("sf_lat_edge_n1", word_valid, 1'b1);
    chk("sf_first_fs",    frame_start, 1'b1);
    chk("sf_first_word",  word_out, 16'h0012);
    nval = 1;
    repeat (9) begin
      tick();
      if (word_valid) nval++;
    end
    chk("sf_valid_cycles", nval, 5);
    chk("sf_len", sink.size(), 5);
    frame_chk("sf", 0, 16'h0012, sf_data);
    if (sink.size() == 5) begin
      chk("sf_lit_w1", sink[1], 16'h4444);
      chk("sf_lit_w4", sink[4], 16'h1111);
    end

    // Backpressure 1,0,0,...
    pulse_reset();
    sink.delete(); sink_fs.delete();
    word_ready = 1'b0;
    do_load(16'h0012, sf_data);
    for (int i = 0; i < 25; i++) begin
      word_ready = (i % 3 == 0);
      tick();
    end
    word_ready = 1'b0;
    chk("bp_len", sink.size(), 5);
    frame_chk("bp", 0, 16'h0012, sf_data);

    // Overflow: 1 in flight + 4 queued, 6th dropped, set wins over clear
    sink.delete(); sink_fs.delete();
    for (int i = 0; i < 6; i++)
      do_load(16'(16'h0100 + i), {4{16'(16'h0A00 + i)}});
    chk("ovf_flag",    overflow, 1'b1);
    chk("ovf_full",    full,     1'b1);
    chk("ovf_pending", pending,  3'd4);
    clear_overflow = 1'b1;
    do_load(16'h0106, {4{16'h0A06}});
    clear_overflow = 1'b0;
    chk("ovf_set_wins", overflow, 1'b1);
    word_ready = 1'b1;
    run(30);
    chk("ovf_frames", count_frames(), 5);
    for (int i = 0; i < 5; i++)
      frame_chk("ovf_order", i, 16'(16'h0100 + i), {4{16'(16'h0A00 + i)}});
    clear_overflow = 1'b1;
    tick();
    clear_overflow = 1'b0;
    chk("ovf_cleared", overflow, 1'b0);

    // Full queue, load on the D3-transfer edge
    word_ready = 1'b0;
    sink.delete(); sink_fs.delete();
    for (int i = 0; i < 5; i++)
      do_load(16'(16'h0200 + i), {4{16'(16'h0B00 + i)}});
    chk("fp_full_pre", full,    1'b1);
    chk("fp_pend_pre", pending, 3'd4);
    word_ready = 1'b1;
    run(4);
    do_load(16'h02AA, 64'hAAAA_BBBB_CCCC_DDDD);
    chk("fp_pending",  pending,  3'd4);
    chk("fp_overflow", overflow, 1'b0);
    chk("fp_full",     full,     1'b1);
    run(40);
    chk("fp_frames", count_frames(), 6);
    frame_chk("fp_first", 0, 16'h0200, {4{16'h0B00}});
    frame_chk("fp_last",  5, 16'h02AA, 64'hAAAA_BBBB_CCCC_DDDD);

    // Reset during D1
    word_ready = 1'b1;
    do_load(16'h0301, 64'h0301_0301_0301_0301);
    do_load(16'h0302, 64'h0302_0302_0302_0302);
    run(2);
    chk("mr_pend_pre", pending, 3'd1);
    rst_n = 1'b0;
    tick();
    chk("mr_valid",   word_valid,  1'b0);
    chk("mr_pending", pending,     3'd0);
    chk("mr_fstart",  frame_start, 1'b0);
    rst_n = 1'b1;
    tick();
    sink.delete(); sink_fs.delete();
    do_load(16'h0303, 64'h1234_5678_9ABC_DEF0);
    run(10);
    chk("mr_len", sink.size(), 5);
    frame_chk("mr_clean", 0, 16'h0303, 64'h1234_5678_9ABC_DEF0);

    // Duplicate loads
    pulse_reset();
    sink.delete(); sink_fs.delete();
    word_ready = 1'b1;
    do_load(16'h0400, 64'h4444_0000_4444_0000);
    do_load(16'h0400, 64'h4444_0000_4444_0000);
    do_load(16'h0401, 64'h5555_0000_5555_0000);
    run(30);
`ifdef EXTENDED_WIRE_SENDER_DEDUP_EN
    exp_frames = 2;
`else
    exp_frames = 3;
`endif
    chk("dd_frames",   count_frames(), exp_frames);
    chk("dd_overflow", overflow, 1'b0);
    frame_chk("dd_first", 0, 16'h0400, 64'h4444_0000_4444_0000);
    frame_chk("dd_last",  exp_frames - 1, 16'h0401, 64'h5555_0000_5555_0000);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
